// File: rtl/l1_req_queue_if.sv
// Handshake bundle between the L1 command source, l1_req_queue and the cache controller.
// The slave modport is the queue's view; master is the source/controller side.
interface l1_req_queue_if #(
    parameter int unsigned OFFSET_BITS = 6,
    parameter int unsigned INDEX_BITS  = 10
);
    localparam int unsigned TAG_BITS = 32 - OFFSET_BITS - INDEX_BITS;

    logic                   l1_valid;
    logic [1:0]             L1cmd;
    logic [31:0]            L1addr;
    logic [31:0]            L1data;
    logic                   stall;

    logic                   ctl_valid;
    logic                   ctl_ready;
    logic [1:0]             ctl_cmd;
    logic [TAG_BITS-1:0]    ctl_tag;
    logic [INDEX_BITS-1:0]  ctl_index;
    logic [OFFSET_BITS-1:0] ctl_offset;
    logic [31:0]            ctl_data;

    modport slave (
        input  l1_valid, L1cmd, L1addr, L1data, ctl_ready,
        output stall, ctl_valid, ctl_cmd, ctl_tag, ctl_index, ctl_offset, ctl_data
    );

    modport master (
        output l1_valid, L1cmd, L1addr, L1data, ctl_ready,
        input  stall, ctl_valid, ctl_cmd, ctl_tag, ctl_index, ctl_offset, ctl_data
    );
endinterface

// File: rtl/l1_req_queue.sv
// L1 command FIFO: buffers read/write/invalidate commands, decodes the head address into
// tag/index/offset for the cache controller, and counts accepted commands per type.
module l1_req_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned OFFSET_BITS = 6,
    parameter int unsigned INDEX_BITS  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    l1_req_queue_if.slave        bus,
    output logic [31:0]          rd_cnt,
    output logic [31:0]          wr_cnt,
    output logic [31:0]          inv_cnt
);
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned TAG_BITS = 32 - OFFSET_BITS - INDEX_BITS;

    typedef enum logic [1:0] {
        CmdRead  = 2'd0,
        CmdWrite = 2'd1,
        CmdInv   = 2'd2,
        CmdNop   = 2'd3
    } cmd_e;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("l1_req_queue: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    // Entry storage is deliberately left out of reset; only pointers and count define validity.
    logic [1:0]  cmd_mem  [DEPTH];
    logic [31:0] addr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      rd_cnt_q, rd_cnt_d;
    logic [31:0]      wr_cnt_q, wr_cnt_d;
    logic [31:0]      inv_cnt_q, inv_cnt_d;

    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic [31:0] head_addr;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A no-op is swallowed by the handshake: neither stored nor counted.
    assign push = bus.l1_valid && !full && (cmd_e'(bus.L1cmd) != CmdNop);
    assign pop  = !empty && bus.ctl_ready;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        inv_cnt_d = inv_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (push) begin
            unique case (cmd_e'(bus.L1cmd))
                CmdRead:  rd_cnt_d  = rd_cnt_q + 32'd1;
                CmdWrite: wr_cnt_d  = wr_cnt_q + 32'd1;
                CmdInv:   inv_cnt_d = inv_cnt_q + 32'd1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            cmd_mem[wr_ptr_q]  <= bus.L1cmd;
            addr_mem[wr_ptr_q] <= bus.L1addr;
            data_mem[wr_ptr_q] <= bus.L1data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            inv_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            inv_cnt_q <= inv_cnt_d;
        end
    end

    assign head_addr      = addr_mem[rd_ptr_q];
    assign bus.stall      = full;
    assign bus.ctl_valid  = !empty;
    assign bus.ctl_cmd    = cmd_mem[rd_ptr_q];
    assign bus.ctl_tag    = head_addr[31 -: TAG_BITS];
    assign bus.ctl_index  = head_addr[OFFSET_BITS +: INDEX_BITS];
    assign bus.ctl_offset = head_addr[OFFSET_BITS-1:0];
    assign bus.ctl_data   = data_mem[rd_ptr_q];

    assign rd_cnt  = rd_cnt_q;
    assign wr_cnt  = wr_cnt_q;
    assign inv_cnt = inv_cnt_q;

    l1cmd_known: assert property (@(posedge clk) disable iff (reset)
        bus.l1_valid |-> !$isunknown(bus.L1cmd))
        else $error("l1_req_queue: L1cmd unknown while l1_valid");
endmodule

// File: tb/tb_l1_req_queue.sv
// Directed testbench for l1_req_queue: reset, decode, full/stall, streaming, no-op,
// mid-run reset and counter wrap, each with hand-computed expectations.
module tb_l1_req_queue;
    logic        clk;
    logic        reset;
    logic [31:0] rd_cnt, wr_cnt, inv_cnt;
    int          checks;
    int          errors;

    l1_req_queue_if #(.OFFSET_BITS(6), .INDEX_BITS(10)) bus ();

    l1_req_queue #(.DEPTH(4), .OFFSET_BITS(6), .INDEX_BITS(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .rd_cnt  (rd_cnt),
        .wr_cnt  (wr_cnt),
        .inv_cnt (inv_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset         = 1'b1;
        bus.l1_valid  = 1'b0;
        bus.ctl_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push_cmd(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] data);
        bus.l1_valid = 1'b1;
        bus.L1cmd    = cmd;
        bus.L1addr   = addr;
        bus.L1data   = data;
        tick();
        bus.l1_valid = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (bus.ctl_valid !== 1'b0) begin errors++; $display("FAIL reset_ctl_valid: got %b want 0", bus.ctl_valid); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
        checks++; if (rd_cnt !== 32'd0) begin errors++; $display("FAIL reset_rd_cnt: got %h want 0", rd_cnt); end
        checks++; if (wr_cnt !== 32'd0) begin errors++; $display("FAIL reset_wr_cnt: got %h want 0", wr_cnt); end
        checks++; if (inv_cnt !== 32'd0) begin errors++; $display("FAIL reset_inv_cnt: got %h want 0", inv_cnt); end
    endtask

    task automatic test_single_read;
        do_reset();
        bus.ctl_ready = 1'b1;
        push_cmd(2'd0, 32'h1234_5678, 32'h0);
        checks++; if (bus.ctl_valid !== 1'b1) begin errors++; $display("FAIL read_valid: got %b want 1", bus.ctl_valid); end
        checks++; if (bus.ctl_cmd !== 2'd0) begin errors++; $display("FAIL read_cmd: got %0d want 0", bus.ctl_cmd); end
        checks++; if (bus.ctl_tag !== 16'h1234) begin errors++; $display("FAIL read_tag: got %h want 1234", bus.ctl_tag); end
        checks++; if (bus.ctl_index !== 10'h159) begin errors++; $display("FAIL read_index: got %h want 159", bus.ctl_index); end
        checks++; if (bus.ctl_offset !== 6'h38) begin errors++; $display("FAIL read_offset: got %h want 38", bus.ctl_offset); end
        checks++; if (rd_cnt !== 32'd1) begin errors++; $display("FAIL read_rd_cnt: got %0d want 1", rd_cnt); end
        tick();
        checks++; if (bus.ctl_valid !== 1'b0) begin errors++; $display("FAIL read_popped: got %b want 0", bus.ctl_valid); end
    endtask

    task automatic test_full_stall;
        logic [31:0] exp_data [3];
        exp_data = '{32'hC, 32'hD, 32'hE};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL fill_stall_%0d: got %b want 0", i, bus.stall); end
            push_cmd(2'd1, 32'(i * 64), 32'(10 + i));
        end
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b want 1", bus.stall); end
        checks++; if (wr_cnt !== 32'd4) begin errors++; $display("FAIL full_wr_cnt: got %0d want 4", wr_cnt); end
        // Fifth command held against stall for two cycles.
        bus.l1_valid = 1'b1;
        bus.L1cmd    = 2'd1;
        bus.L1addr   = 32'h100;
        bus.L1data   = 32'hE;
        tick();
        tick();
        checks++; if (wr_cnt !== 32'd4) begin errors++; $display("FAIL held_wr_cnt: got %0d want 4", wr_cnt); end
        checks++; if (bus.ctl_data !== 32'hA) begin errors++; $display("FAIL head_a: got %h want a", bus.ctl_data); end
        bus.ctl_ready = 1'b1;
        tick();
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL stall_drop: got %b want 0", bus.stall); end
        checks++; if (wr_cnt !== 32'd4) begin errors++; $display("FAIL no_same_cycle_push: got %0d want 4", wr_cnt); end
        checks++; if (bus.ctl_data !== 32'hB) begin errors++; $display("FAIL head_b: got %h want b", bus.ctl_data); end
        checks++; if (bus.ctl_index !== 10'd1) begin errors++; $display("FAIL head_b_index: got %h want 1", bus.ctl_index); end
        tick();
        bus.l1_valid = 1'b0;
        checks++; if (wr_cnt !== 32'd5) begin errors++; $display("FAIL fifth_accepted: got %0d want 5", wr_cnt); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.ctl_valid !== 1'b1 || bus.ctl_data !== exp_data[k]) begin
                errors++; $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", k, bus.ctl_valid, bus.ctl_data, exp_data[k]);
            end
            tick();
        end
        checks++; if (bus.ctl_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", bus.ctl_valid); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        push_cmd(2'd1, 32'h0, 32'd100);
        push_cmd(2'd1, 32'h40, 32'd101);
        bus.ctl_ready = 1'b1;
        bus.l1_valid  = 1'b1;
        bus.L1cmd     = 2'd1;
        for (int i = 0; i < 10; i++) begin
            bus.L1addr = 32'((i + 2) * 64);
            bus.L1data = 32'(102 + i);
            checks++; if (bus.ctl_valid !== 1'b1 || bus.ctl_data !== 32'(100 + i) || bus.stall !== 1'b0) begin
                errors++; $display("FAIL stream_%0d: got v=%b d=%0d s=%b want v=1 d=%0d s=0",
                                   i, bus.ctl_valid, bus.ctl_data, bus.stall, 100 + i);
            end
            tick();
        end
        bus.l1_valid = 1'b0;
        checks++; if (wr_cnt !== 32'd12) begin errors++; $display("FAIL stream_wr_cnt: got %0d want 12", wr_cnt); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (bus.ctl_valid !== 1'b1 || bus.ctl_data !== 32'(110 + i)) begin
                errors++; $display("FAIL stream_tail_%0d: got v=%b d=%0d want v=1 d=%0d", i, bus.ctl_valid, bus.ctl_data, 110 + i);
            end
            tick();
        end
        checks++; if (bus.ctl_valid !== 1'b0) begin errors++; $display("FAIL stream_empty: got %b want 0", bus.ctl_valid); end
    endtask

    task automatic test_noop;
        do_reset();
        push_cmd(2'd0, 32'h40, 32'h1);
        push_cmd(2'd3, 32'h999, 32'h2);
        push_cmd(2'd2, 32'h80, 32'h3);
        checks++; if (rd_cnt !== 32'd1 || inv_cnt !== 32'd1 || wr_cnt !== 32'd0) begin
            errors++; $display("FAIL noop_counts: got rd=%0d wr=%0d inv=%0d want 1 0 1", rd_cnt, wr_cnt, inv_cnt);
        end
        bus.ctl_ready = 1'b1;
        checks++; if (bus.ctl_cmd !== 2'd0) begin errors++; $display("FAIL noop_first: got %0d want 0", bus.ctl_cmd); end
        tick();
        checks++; if (bus.ctl_valid !== 1'b1 || bus.ctl_cmd !== 2'd2) begin
            errors++; $display("FAIL noop_second: got v=%b c=%0d want v=1 c=2", bus.ctl_valid, bus.ctl_cmd);
        end
        tick();
        checks++; if (bus.ctl_valid !== 1'b0) begin errors++; $display("FAIL noop_empty: got %b want 0", bus.ctl_valid); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        for (int i = 0; i < 3; i++) push_cmd(2'd1, 32'(i * 64), 32'(i));
        checks++; if (bus.ctl_valid !== 1'b1) begin errors++; $display("FAIL mid_queued: got %b want 1", bus.ctl_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.ctl_valid !== 1'b0 || bus.stall !== 1'b0) begin
            errors++; $display("FAIL mid_flush: got v=%b s=%b want 0 0", bus.ctl_valid, bus.stall);
        end
        checks++; if (rd_cnt !== 32'd0 || wr_cnt !== 32'd0 || inv_cnt !== 32'd0) begin
            errors++; $display("FAIL mid_counters: got rd=%0d wr=%0d inv=%0d want 0 0 0", rd_cnt, wr_cnt, inv_cnt);
        end
        bus.ctl_ready = 1'b1;
        push_cmd(2'd0, 32'h2000_0040, 32'h55);
        checks++; if (bus.ctl_valid !== 1'b1 || bus.ctl_cmd !== 2'd0 || bus.ctl_tag !== 16'h2000 || bus.ctl_index !== 10'd1) begin
            errors++; $display("FAIL mid_read: got v=%b c=%0d t=%h i=%h want 1 0 2000 1",
                               bus.ctl_valid, bus.ctl_cmd, bus.ctl_tag, bus.ctl_index);
        end
        tick();
        checks++; if (bus.ctl_valid !== 1'b0 || rd_cnt !== 32'd1) begin
            errors++; $display("FAIL mid_only_entry: got v=%b rd=%0d want 0 1", bus.ctl_valid, rd_cnt);
        end
    endtask

    task automatic test_counter_wrap;
        do_reset();
        force dut.inv_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.inv_cnt_q;
        checks++; if (inv_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preset: got %h want ffffffff", inv_cnt); end
        push_cmd(2'd2, 32'h0, 32'h0);
        checks++; if (inv_cnt !== 32'd0) begin errors++; $display("FAIL wrap_inv_cnt: got %h want 0", inv_cnt); end
        checks++; if (rd_cnt !== 32'd0 || wr_cnt !== 32'd0) begin
            errors++; $display("FAIL wrap_others: got rd=%0d wr=%0d want 0 0", rd_cnt, wr_cnt);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.l1_valid  = 1'b0;
        bus.L1cmd     = 2'd3;
        bus.L1addr    = 32'h0;
        bus.L1data    = 32'h0;
        bus.ctl_ready = 1'b0;
        test_reset();
        test_single_read();
        test_full_stall();
        test_back_to_back();
        test_noop();
        test_reset_mid();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/l1_req_queue.md
Name: l1_req_queue

Overview:
- Sits directly downstream of the trace-driven L1 command source and upstream of the cache controller core.
- Accepts L1 commands (cmd, 32-bit address, 32-bit write data) into a FIFO and back-pressures the source with stall.
- Decodes each head entry into tag/index/offset and presents it to the controller over a valid/ready handshake.
- Keeps per-command-type event counters for end-of-run statistics.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- OFFSET_BITS, 6, byte-offset field width (64-byte lines).
- INDEX_BITS, 10, set-index field width; tag width is 32-OFFSET_BITS-INDEX_BITS.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- l1_valid  in  1  L1cmd, L1addr and L1data carry a command this cycle.
- L1cmd  in  2  0=read, 1=write, 2=invalidate, 3=no-op.
- L1addr  in  32  byte address.
- L1data  in  32  write data. Sampled only; never driven by this block.
- stall  out  1  high means the source must hold its current command.
- ctl_valid  out  1  the head entry is presented.
- ctl_ready  in  1  the controller accepts the head entry.
- ctl_cmd  out  2  head command (0..2 only).
- ctl_tag  out  32-OFFSET_BITS-INDEX_BITS  L1addr[31:OFFSET_BITS+INDEX_BITS].
- ctl_index  out  INDEX_BITS  L1addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS].
- ctl_offset  out  OFFSET_BITS  L1addr[OFFSET_BITS-1:0].
- ctl_data  out  32  head write data. Equals the stored L1data for every command type.
- rd_cnt, wr_cnt, inv_cnt  out  32 each  accepted reads, writes and invalidates.

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries (cmd, addr, data).
  - Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy counter runs 0..DEPTH.
- Push:
  - Occurs when l1_valid && !stall && L1cmd != 3.
  - A no-op (cmd 3) is consumed: it is not stored and not counted, and stall is unaffected.
- Pop:
  - Occurs when ctl_valid && ctl_ready.
  - ctl_valid = (count != 0). All ctl_* outputs are driven combinationally from the head-entry registers.
- Latency: a command pushed at edge N appears on ctl_* after edge N, i.e. 1 cycle. There is no bypass when the FIFO is empty.
- stall:
  - stall = (count == DEPTH), derived from the registered count.
  - While full, a simultaneous pop does not enable a same-cycle push. Stall drops the cycle after the pop.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Empty: ctl_ready is ignored. ctl_cmd, ctl_tag, ctl_index, ctl_offset and ctl_data hold stale head contents and are don't-care.
- Counters:
  - Increment on push according to command.
  - Wrap modulo 2^32 and never saturate.
- Reset:
  - Pointers, count and counters go to 0, so stall=0 and ctl_valid=0. Stored entries are not cleared.
  - Reset mid-operation discards all queued entries. The source must resend; the block never replays them.
- Input integrity: X/Z on L1cmd while l1_valid=1 is a bench error. Behaviour in that case is not defined.

Test Plan:
- Reset, then a single read at 0x1234_5678 with ctl_ready=1 → ctl_valid=1 one cycle later, ctl_tag=0x1234, ctl_index=0x159, ctl_offset=0x38; popped that cycle; rd_cnt=1.
- ctl_ready=0 and 4 writes (addr 0x0,0x40,0x80,0xC0, data 0xA..0xD) → stall=1 after the 4th push. A 5th command is held, not stored, and wr_cnt=4. Then ctl_ready=1 → entries drain in order with data 0xA..0xD. Stall falls the cycle after the first pop and the 5th command is then accepted.
- Continuous push and pop at count=2 for 10 cycles → count stays 2 and pointers wrap past DEPTH with order preserved.
- No-op (cmd 3) interleaved between a read and an invalidate → only 2 entries queued; rd_cnt=1, inv_cnt=1; no-op never appears on ctl_cmd.
- Reset asserted with 3 entries queued and ctl_ready=0 → next cycle ctl_valid=0, stall=0, all counters 0. A following read is the only entry presented.
- Counter preset to 0xFFFF_FFFF via force, then one invalidate → inv_cnt=0.
